uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_rx_fifo.sv | 75 +++++++
 rtl/uart_rx.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver:
//   - rx_state_e     : receiver FSM state encoding
//   - calc_div/half  : clocks per bit / per half bit from clock and baud rate
//   - RX_DATA_W, RX_FIFO_DEPTH : byte width and optional FIFO depth
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package uart_pkg;

    localparam int unsigned RX_DATA_W     = 8;
    localparam int unsigned RX_FIFO_DEPTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_e;

    // Clocks per bit, truncating.
    function automatic int unsigned calc_div(input int unsigned clock_hz,
                                             input int unsigned baud);
        return clock_hz / baud;
    endfunction

    // Clocks to the middle of the start bit.
    function automatic int unsigned calc_half(input int unsigned clock_hz,
                                              input int unsigned baud);
        return calc_div(clock_hz, baud) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// 4-entry x 8-bit FIFO holding received bytes until the consumer takes them.
// A pop and a push in the same cycle are both honoured, even when full
// (the pop frees the slot the push uses).
// Ports:
//   clk, n_reset   : clock, asynchronous active-low reset
//   push, wr_data  : write request and byte
//   pop            : read request (ignored when empty)
//   rd_data        : head entry (0 after reset)
//   full, empty    : occupancy flags
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_rx_fifo
    import uart_pkg::*;
(
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 push,
    input  logic [RX_DATA_W-1:0] wr_data,
    input  logic                 pop,
    output logic [RX_DATA_W-1:0] rd_data,
    output logic                 full,
    output logic                 empty
);

    logic [RX_DATA_W-1:0] mem_q [RX_FIFO_DEPTH];
    logic [RX_DATA_W-1:0] mem_d [RX_FIFO_DEPTH];
    logic [1:0]           wr_ptr_q, wr_ptr_d;
    logic [1:0]           rd_ptr_q, rd_ptr_d;
    logic [2:0]           count_q, count_d;
    logic                 do_push, do_pop;

    assign empty   = (count_q == 3'd0);
    assign full    = (count_q == 3'(RX_FIFO_DEPTH));
    assign rd_data = mem_q[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < int'(RX_FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver, LSB first, idle-high line. Each bit is sampled once:
// the start bit at its middle (HALF clocks after the falling edge), the data
// and stop bits every DIV clocks after that.
//
// Handshake: rx_valid/rx_data present the oldest stored byte. A byte is
// consumed on a rising clk edge where rx_valid & rx_ready. While rx_valid=1
// and rx_ready=0 both outputs hold. rx_ready has no effect while rx_valid=0.
//
// Build option: define UART_RX_FIFO_EN to store up to 4 bytes in a FIFO;
// otherwise a single holding register is used.
//
// Ports:
//   clk, n_reset   : clock, asynchronous active-low reset
//   uart_rx_pin    : asynchronous serial input
//   rx_data        : received byte (valid while rx_valid)
//   rx_valid       : byte available
//   rx_ready       : consumer accepts byte
//   frame_error    : one-cycle pulse, stop bit sampled low
//   overrun        : one-cycle pulse, completed byte dropped (storage full)
//   dbg_state      : current FSM state (rx_state_e encoding)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned UART_CLOCK_HZ = 20_000_000,
    parameter int unsigned UART_BAUD     = 115200
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       uart_rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_error,
    output logic       overrun,
    output logic [2:0] dbg_state
);

    localparam int unsigned DIV  = calc_div(UART_CLOCK_HZ, UART_BAUD);
    localparam int unsigned HALF = calc_half(UART_CLOCK_HZ, UART_BAUD);
    localparam int unsigned CW   = $clog2(DIV) + 1;
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    rx_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        sync1_q, sync1_d, sync2_q, sync2_d;
    logic        frame_error_q, frame_error_d;
    logic        overrun_q, overrun_d;
    logic        deliver;
    logic        pop;
    logic        rx_s;

    assign sync1_d     = uart_rx_pin;
    assign sync2_d     = sync1_q;
    assign rx_s        = sync2_q;
    assign dbg_state   = state_q;
    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;
    assign pop         = rx_valid & rx_ready;

    // Receiver FSM; deliver is high for the single cycle of a good stop-bit sample.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        deliver       = 1'b0;
        frame_error_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d   = ST_START;
                    bit_cnt_d = 3'd0;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    // A high line here was a glitch, not a start bit.
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_q == DIV_M1) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_q == DIV_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        deliver = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_error_d = 1'b1;
                        state_d       = ST_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_HIGH: begin
                // A held-low (break) line must not look like a new start bit.
                cnt_d = '0;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'd0;
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
        end
    end

`ifdef UART_RX_FIFO_EN
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_push;
    logic [7:0] fifo_rd_data;

    // A pop in the delivery cycle frees a slot, so a full FIFO still accepts.
    assign fifo_push = deliver & (~fifo_full | pop);
    assign overrun_d = deliver & fifo_full & ~pop;
    assign rx_valid  = ~fifo_empty;
    assign rx_data   = fifo_rd_data;

    uart_rx_fifo u_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .push    (fifo_push),
        .wr_data (shift_q),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );
`else
    logic [7:0] hold_data_q, hold_data_d;
    logic       hold_valid_q, hold_valid_d;

    assign rx_valid = hold_valid_q;
    assign rx_data  = hold_data_q;

    // Pop is applied first so a byte arriving in the pop cycle is kept.
    always_comb begin
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        overrun_d    = 1'b0;
        if (pop) begin
            hold_valid_d = 1'b0;
        end
        if (deliver) begin
            if (!hold_valid_q || pop) begin
                hold_data_d  = shift_q;
                hold_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            hold_data_q  <= 8'd0;
            hold_valid_q <= 1'b0;
        end else begin
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
        end
    end
`endif

endmodule
